pokemon_match_ctrl: RTL

POKEMON_MATCH_CTRL -- requirements
Module: pokemon_match_ctrl

---
 rtl/pokemon_pkg.sv | 39 +++
 rtl/pokemon_match_ctrl_if.sv | 28 ++
 rtl/pokemon_rise_detect.sv | 22 ++
 rtl/pokemon_match_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pokemon_pkg.sv
// Shared types and constants for the Pokemon match controller: FSM encoding,
// winner codes, per-round shoot cooldowns and default tick lengths.
package pokemon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_ROUND_END = 3'd3,
      ST_MATCH_END = 3'd4
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam logic [5:0] SLOW_SHOOT_RATE   = 6'd20;
   localparam logic [5:0] MEDIUM_SHOOT_RATE = 6'd15;
   localparam logic [5:0] FAST_SHOOT_RATE   = 6'd10;

   localparam int DEFAULT_COUNT_TICKS   = 60;
   localparam int DEFAULT_HOLD_TICKS    = 40;
   localparam int DEFAULT_WINS_TO_MATCH = 2;
   localparam int TICK_W                = 8;

   // Later rounds fire faster; round 0 (idle) keeps the round-1 rate.
   function automatic logic [5:0] rate_for_round(input logic [1:0] rnd);
      logic [5:0] rate;
      case (rnd)
         2'd1:    rate = SLOW_SHOOT_RATE;
         2'd2:    rate = MEDIUM_SHOOT_RATE;
         2'd3:    rate = FAST_SHOOT_RATE;
         default: rate = SLOW_SHOOT_RATE;
      endcase
      return rate;
   endfunction

endpackage

// File: rtl/pokemon_match_ctrl_if.sv
// Signal bundle between the match controller (master) and the game logic
// block (slave) that consumes the round control outputs.
interface pokemon_match_ctrl_if;
   logic       start;
   logic       charmander_alive;
   logic       squirtle_alive;
   logic       game_run;
   logic       round_restart;
   logic [1:0] countdown_sec;
   logic [1:0] p1_wins;
   logic [1:0] p2_wins;
   logic [1:0] round_num;
   logic [1:0] winner;
   logic [5:0] shoot_rate;
   logic [2:0] state;

   modport master (
      input  start, charmander_alive, squirtle_alive,
      output game_run, round_restart, countdown_sec, p1_wins, p2_wins,
             round_num, winner, shoot_rate, state
   );

   modport slave (
      output start, charmander_alive, squirtle_alive,
      input  game_run, round_restart, countdown_sec, p1_wins, p2_wins,
             round_num, winner, shoot_rate, state
   );
endinterface

// File: rtl/pokemon_rise_detect.sv
// Rising-edge detector: compares the input with its value from the previous tick.
module pokemon_rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_q;

   // One-tick history of the input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_q <= 1'b0;
      end else begin
         din_q <= din;
      end
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/pokemon_match_ctrl.sv
// Best-of-N match sequencer: countdown, play, round-end hold and match-end,
// with score keeping and per-round shoot cooldown selection.
module pokemon_match_ctrl
   import pokemon_pkg::*;
#(
   parameter int COUNT_TICKS   = DEFAULT_COUNT_TICKS,
   parameter int HOLD_TICKS    = DEFAULT_HOLD_TICKS,
   parameter int WINS_TO_MATCH = DEFAULT_WINS_TO_MATCH
) (
   input  logic                  clk_20Hz,
   input  logic                  reset,
   pokemon_match_ctrl_if.master  bus
);

   localparam logic [TICK_W-1:0] COUNT_LOAD = TICK_W'(COUNT_TICKS - 1);
   localparam logic [TICK_W-1:0] HOLD_LOAD  = TICK_W'(HOLD_TICKS - 1);
   localparam logic [TICK_W-1:0] SEC3_MIN   = TICK_W'((2 * COUNT_TICKS) / 3);
   localparam logic [TICK_W-1:0] SEC2_MIN   = TICK_W'(COUNT_TICKS / 3);
   localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
   localparam logic [TICK_W-1:0] TICK_ZERO  = TICK_W'(0);
   localparam logic [1:0]        WIN_SCORE  = 2'(WINS_TO_MATCH);

   state_t            fsm_state;
   logic [TICK_W-1:0] tick;
   logic              start_rise;
   logic              game_run;
   logic              round_restart;
   logic [1:0]        countdown_sec;
   logic [1:0]        p1_wins;
   logic [1:0]        p2_wins;
   logic [1:0]        round_num;
   logic [1:0]        winner;
   logic [5:0]        shoot_rate;

   pokemon_rise_detect u_start_rise (
      .clk  (clk_20Hz),
      .rst  (reset),
      .din  (bus.start),
      .rise (start_rise)
   );

   // Counter thirds map onto the 3/2/1 seconds shown to the players.
   function automatic logic [1:0] sec_for(input logic [TICK_W-1:0] t);
      logic [1:0] sec;
      if (t >= SEC3_MIN) begin
         sec = 2'd3;
      end else if (t >= SEC2_MIN) begin
         sec = 2'd2;
      end else begin
         sec = 2'd1;
      end
      return sec;
   endfunction

   // Match FSM; every output is registered alongside the state.
   always_ff @(posedge clk_20Hz or posedge reset) begin
      if (reset) begin
         fsm_state     <= ST_IDLE;
         tick          <= TICK_ZERO;
         game_run      <= 1'b0;
         round_restart <= 1'b0;
         countdown_sec <= 2'd0;
         p1_wins       <= 2'd0;
         p2_wins       <= 2'd0;
         round_num     <= 2'd0;
         winner        <= WIN_NONE;
         shoot_rate    <= SLOW_SHOOT_RATE;
      end else begin
         round_restart <= 1'b0;
         case (fsm_state)
            ST_IDLE, ST_MATCH_END: begin
               if (start_rise) begin
                  p1_wins       <= 2'd0;
                  p2_wins       <= 2'd0;
                  round_num     <= 2'd1;
                  winner        <= WIN_NONE;
                  shoot_rate    <= rate_for_round(2'd1);
                  tick          <= COUNT_LOAD;
                  countdown_sec <= sec_for(COUNT_LOAD);
                  round_restart <= 1'b1;
                  fsm_state     <= ST_COUNTDOWN;
               end
            end
            ST_COUNTDOWN: begin
               if (tick == TICK_ZERO) begin
                  countdown_sec <= 2'd0;
                  game_run      <= 1'b1;
                  fsm_state     <= ST_PLAY;
               end else begin
                  tick          <= tick - TICK_ONE;
                  countdown_sec <= sec_for(tick - TICK_ONE);
               end
            end
            ST_PLAY: begin
               // A simultaneous knockout is a draw and scores nobody.
               if (!bus.charmander_alive || !bus.squirtle_alive) begin
                  game_run  <= 1'b0;
                  tick      <= HOLD_LOAD;
                  fsm_state <= ST_ROUND_END;
                  if (!bus.charmander_alive && !bus.squirtle_alive) begin
                     winner <= WIN_DRAW;
                  end else if (!bus.squirtle_alive) begin
                     winner <= WIN_P1;
                     if (p1_wins < WIN_SCORE) begin
                        p1_wins <= p1_wins + 2'd1;
                     end
                  end else begin
                     winner <= WIN_P2;
                     if (p2_wins < WIN_SCORE) begin
                        p2_wins <= p2_wins + 2'd1;
                     end
                  end
               end
            end
            ST_ROUND_END: begin
               if (tick != TICK_ZERO) begin
                  tick <= tick - TICK_ONE;
               end else if (p1_wins == WIN_SCORE || p2_wins == WIN_SCORE) begin
                  fsm_state <= ST_MATCH_END;
               end else begin
                  // Draws leave the scores alone, so the same round is replayed.
                  round_num     <= p1_wins + p2_wins + 2'd1;
                  shoot_rate    <= rate_for_round(p1_wins + p2_wins + 2'd1);
                  tick          <= COUNT_LOAD;
                  countdown_sec <= sec_for(COUNT_LOAD);
                  round_restart <= 1'b1;
                  fsm_state     <= ST_COUNTDOWN;
               end
            end
            default: begin
               fsm_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.state         = fsm_state;
   assign bus.game_run      = game_run;
   assign bus.round_restart = round_restart;
   assign bus.countdown_sec = countdown_sec;
   assign bus.p1_wins       = p1_wins;
   assign bus.p2_wins       = p2_wins;
   assign bus.round_num     = round_num;
   assign bus.winner        = winner;
   assign bus.shoot_rate    = shoot_rate;

endmodule
